// File: rtl/mux2_rr_stream_if.sv
// mux2_rr_stream_if: stream bundle for the 2:1 round-robin selector
// Signals:
//   d0, d0_valid, d0_ready  channel 0 producer handshake
//   d1, d1_valid, d1_ready  channel 1 producer handshake
//   y, y_valid, y_ready     registered output stream
//   s                       channel that produced the current y
// Modports:
//   master  drives the producers and the consumer ready (testbench / upstream side)
//   slave   the selector itself
interface mux2_rr_stream_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] y;
    logic             d0_valid;
    logic             d0_ready;
    logic             d1_valid;
    logic             d1_ready;
    logic             y_valid;
    logic             y_ready;
    logic             s;
    modport master (
        output d0, d0_valid, d1, d1_valid, y_ready,
        input  d0_ready, d1_ready, y, y_valid, s
    );
    modport slave (
        input  d0, d0_valid, d1, d1_valid, y_ready,
        output d0_ready, d1_ready, y, y_valid, s
    );
endinterface

// File: rtl/mux2_rr_stream.sv
// mux2_rr_stream: registered, flow-controlled 2:1 stream selector with round-robin or fixed priority
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of mux2_rr_stream_if: two valid/ready producers in,
//          one-entry registered output stream (y, y_valid, y_ready) and select s out
module mux2_rr_stream #(
    parameter int WIDTH   = 4,
    parameter bit RR_MODE = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mux2_rr_stream_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             s_q, s_d;
    logic             last_grant_q, last_grant_d;
    logic             can_load;
    logic             grant;
    logic             g;
    always_comb begin
        // the output register can take a word when empty or when it is being drained this cycle
        can_load     = (state_q == EMPTY) | bus.y_ready;
        // on a tie, the channel that did not win last time goes; a single requester always wins
        g            = (bus.d0_valid & bus.d1_valid) ? (RR_MODE ? ~last_grant_q : 1'b0) : bus.d1_valid;
        grant        = rst_n & can_load & (bus.d0_valid | bus.d1_valid);
        state_d      = grant ? FULL : (bus.y_ready ? EMPTY : state_q);
        y_d          = grant ? (g ? bus.d1 : bus.d0) : y_q;
        s_d          = grant ? g : s_q;
        // priority rotates only on a real transfer, never on idle cycles
        last_grant_d = grant ? g : last_grant_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            y_q          <= '0;
            s_q          <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            s_q          <= s_d;
            last_grant_q <= last_grant_d;
        end
    end
    assign bus.d0_ready = grant & ~g;
    assign bus.d1_ready = grant & g;
    assign bus.y        = y_q;
    assign bus.y_valid  = (state_q == FULL);
    assign bus.s        = s_q;
endmodule

// File: tb/tb_mux2_rr_stream.sv
// tb_mux2_rr_stream: directed vector table plus scoreboard for the 2:1 round-robin stream selector
module tb_mux2_rr_stream;
    typedef struct {
        logic       rst_n;
        logic [3:0] d0;
        logic       v0;
        logic [3:0] d1;
        logic       v1;
        logic       yr;
        logic       r0;
        logic       r1;
        logic [3:0] y;
        logic       yv;
        logic       s;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];
    logic [4:0] sbq[$];
    mux2_rr_stream_if #(.WIDTH(4)) a_if ();
    mux2_rr_stream_if #(.WIDTH(4)) b_if ();
    mux2_rr_stream #(.WIDTH(4), .RR_MODE(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(a_if));
    mux2_rr_stream #(.WIDTH(4), .RR_MODE(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(b_if));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic add(input logic r, input logic [3:0] d0, input logic v0, input logic [3:0] d1,
                       input logic v1, input logic yr, input logic r0, input logic r1,
                       input logic [3:0] y, input logic yv, input logic s);
        vec_t v;
        v.rst_n = r; v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1; v.yr = yr;
        v.r0 = r0; v.r1 = r1; v.y = y; v.yv = yv; v.s = s;
        vq.push_back(v);
    endtask
    task automatic set_in(input logic r, input logic [3:0] d0, input logic v0, input logic [3:0] d1,
                          input logic v1, input logic yr);
        rst_n = r;
        a_if.d0 = d0; a_if.d0_valid = v0; a_if.d1 = d1; a_if.d1_valid = v1; a_if.y_ready = yr;
        b_if.d0 = d0; b_if.d0_valid = v0; b_if.d1 = d1; b_if.d1_valid = v1; b_if.y_ready = yr;
    endtask
    // one clock: one-hot ready checks, then in-order scoreboard of the round-robin instance
    task automatic cycle();
        logic       a0, a1, cons, ps, rs;
        logic [3:0] pd0, pd1, py;
        logic [4:0] e;
        #1;
        chk("onehot_rr", 5'(a_if.d0_ready & a_if.d1_ready), 5'd0);
        chk("onehot_fp", 5'(b_if.d0_ready & b_if.d1_ready), 5'd0);
        a0 = a_if.d0_valid & a_if.d0_ready;
        a1 = a_if.d1_valid & a_if.d1_ready;
        cons = a_if.y_valid & a_if.y_ready;
        pd0 = a_if.d0; pd1 = a_if.d1; py = a_if.y; ps = a_if.s; rs = rst_n;
        @(posedge clk);
        if (!rs) sbq.delete();
        else begin
            if (cons) begin
                chk("sb_nonempty", 5'(sbq.size() != 0), 5'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("sb_word", {ps, py}, e);
                end
            end
            if (a0) sbq.push_back({1'b0, pd0});
            if (a1) sbq.push_back({1'b1, pd1});
        end
        @(negedge clk);
    endtask
    initial begin
        // reset held two cycles with both inputs valid
        add(0, 4'h3, 1, 4'hC, 1, 1, 0, 0, 4'h0, 0, 0);
        add(0, 4'h3, 1, 4'hC, 1, 1, 0, 0, 4'h0, 0, 0);
        // single channel d0 then d1, then idle drain
        add(1, 4'h1, 1, 4'h0, 0, 1, 1, 0, 4'h1, 1, 0);
        add(1, 4'h0, 0, 4'hF, 1, 1, 0, 1, 4'hF, 1, 1);
        add(1, 4'h0, 0, 4'hF, 0, 1, 0, 0, 4'hF, 0, 1);
        // round-robin tie, one word per cycle
        add(1, 4'hA, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 0);
        add(1, 4'hA, 1, 4'h5, 1, 1, 0, 1, 4'h5, 1, 1);
        add(1, 4'hA, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 0);
        add(1, 4'hA, 1, 4'h5, 1, 1, 0, 1, 4'h5, 1, 1);
        // load 1010, then backpressure for 3 cycles with d1 waiting
        add(1, 4'hA, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 0);
        add(1, 4'hA, 0, 4'h5, 1, 0, 0, 0, 4'hA, 1, 0);
        add(1, 4'hA, 0, 4'h5, 1, 0, 0, 0, 4'hA, 1, 0);
        add(1, 4'hA, 0, 4'h5, 1, 0, 0, 0, 4'hA, 1, 0);
        // drain and refill from d1 in the same cycle, then idle (no rotation)
        add(1, 4'hA, 0, 4'h5, 1, 1, 0, 1, 4'h5, 1, 1);
        add(1, 4'hA, 0, 4'h5, 0, 1, 0, 0, 4'h5, 0, 1);
        add(1, 4'hA, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 0);
        add(1, 4'hA, 1, 4'h5, 1, 1, 0, 1, 4'h5, 1, 1);
        add(1, 4'hA, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 0);
        // reset while full with d1 next in line; afterwards d0 wins again
        add(0, 4'hA, 1, 4'h5, 1, 1, 0, 0, 4'h0, 0, 0);
        add(1, 4'hA, 1, 4'h5, 1, 1, 1, 0, 4'hA, 1, 0);
        foreach (vq[i]) begin
            set_in(vq[i].rst_n, vq[i].d0, vq[i].v0, vq[i].d1, vq[i].v1, vq[i].yr);
            #1;
            chk($sformatf("v%0d_d0_ready", i), 5'(a_if.d0_ready), 5'(vq[i].r0));
            chk($sformatf("v%0d_d1_ready", i), 5'(a_if.d1_ready), 5'(vq[i].r1));
            cycle();
            chk($sformatf("v%0d_y", i), 5'(a_if.y), 5'(vq[i].y));
            chk($sformatf("v%0d_y_valid", i), 5'(a_if.y_valid), 5'(vq[i].yv));
            chk($sformatf("v%0d_s", i), 5'(a_if.s), 5'(vq[i].s));
        end
        // fixed priority: d0 always wins while both are valid
        set_in(1, 4'hA, 1, 4'h5, 1, 1);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fp_d1_ready", 5'(b_if.d1_ready), 5'd0);
            chk("fp_d0_ready", 5'(b_if.d0_ready), 5'd1);
            cycle();
            chk("fp_s", 5'(b_if.s), 5'd0);
            chk("fp_y", 5'(b_if.y), 5'hA);
            chk("fp_y_valid", 5'(b_if.y_valid), 5'd1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
